trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter VECTOR, default 32'h0000_0100, trap handler entry address.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 m_pc, m_nextpc  in  32 each  retiring instruction address / sequential successor.
REQ-005 m_res  in  32  result for register file; m_rd  in  5  destination; m_w_rd  in  1  rd write request.
REQ-006 m_cmp_res  in  2  compare result; m_w_cr  in  1  condition-register write request.
REQ-007 m_op3  in  32  system-register write data; m_alu_res  in  32  system-register index in [1:0]; m_mtsr  in  1  system-register write.
REQ-008 m_scall, m_eret, m_udf  in  1 each  syscall / exception return / undefined instruction.
REQ-009 m_bubble, m_stall  in  1 each  slot empty / stage stalled.
REQ-010 rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32  register file write port.
REQ-011 cr_we  out  1, cr_wdata  out  2  condition-register write port.
REQ-012 flush  out  1  kill all younger pipeline stages.
REQ-013 redir_valid  out  1, redir_pc  out  32  fetch redirect.
REQ-014 epc  out  32, cause  out  2, ie  out  1  architectural system-register state.

Function
REQ-015 Retire = !m_bubble && !m_stall && state==RUN; no other cycle has architectural effect.
REQ-016 Writeback outputs registered: retire in cycle N drives rf_*/cr_* in N+1 only; rf_we = m_w_rd && rd!=0 && no trap; cr_we = m_w_cr && no trap.
REQ-017 Priority on retire: udf > scall > eret > mtsr > normal.
REQ-018 udf: epc<=m_pc, cause<=2'd2, ie<=0, rf/cr writes suppressed, state RUN->FLUSH.
REQ-019 scall: epc<=m_nextpc, cause<=2'd1, ie<=0, writes suppressed, RUN->FLUSH.
REQ-020 eret: ie<=1, target latched =epc value at retire, RUN->FLUSH.
REQ-021 mtsr: index 0 epc<=m_op3, 1 cause<=m_op3[1:0], 2 ie<=m_op3[0], 3 ignored; no redirect.
REQ-022 FLUSH (1 cycle): flush=1; all mem inputs ignored; ->REDIR.
REQ-023 REDIR (1 cycle): redir_valid=1, redir_pc=VECTOR (trap) or latched epc (eret); inputs ignored; ->RUN.
REQ-024 flush and redir_valid are registered state decodes, never asserted in RUN.
REQ-025 Stall held on a trapping instruction: no state change until stall drops.
REQ-026 Trap/eret latency: retire N, flush N+1, redirect N+2, next retire earliest N+3.

Reset
REQ-027 On rst: state RUN, all outputs 0, epc=0, cause=0, ie=0, latched target=0.
REQ-028 rst asserted in FLUSH/REDIR aborts the sequence; no redirect issued after release.

Configuration
REQ-029 Macro TRAP_CTRL_IRQ_EN: adds port irq in 1 (level, synchronous to clk).
REQ-030 With macro: irq && ie on a non-trapping retire -> instruction completes writeback, epc<=m_nextpc, cause<=2'd3, ie<=0, RUN->FLUSH, redirect to VECTOR; eret retire masks irq that cycle.
REQ-031 Without macro: no irq port; cause 3 never generated; all else identical.

Structure
REQ-032 Shared package holds state enum (RUN, FLUSH, REDIR), cause encodings (NONE=0, SCALL=1, UDF=2, IRQ=3) and sysreg index constants (EPC=0, CAUSE=1, STATUS=2).
REQ-033 Single module; no sub-module; ports may bind to the mem-stage interface consumer modport.

Verification
REQ-034 Normal retire m_rd=5, m_res=32'hDEAD_BEEF, m_w_rd=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF; m_rd=0 -> rf_we=0.
REQ-035 scall at m_pc=32'h40, m_nextpc=32'h44 -> epc=32'h44, cause=1, ie=0, flush at N+1, redir_valid with redir_pc=32'h100 at N+2, rf_we=0.
REQ-036 udf+scall same slot at m_pc=32'h80 -> cause=2, epc=32'h80; inputs during FLUSH/REDIR produce no writes.
REQ-037 mtsr idx0 op3=32'h200 then eret -> ie=1, redir_pc=32'h200 two cycles after eret retire.
REQ-038 m_stall=1 for 3 cycles with m_udf=1 -> no flush until stall drops; rst pulsed during FLUSH -> no redir_valid afterward, all outputs 0.
REQ-039 (TRAP_CTRL_IRQ_EN) ie=1, irq=1, retire m_nextpc=32'h10 with m_w_rd=1 -> rf_we=1, epc=32'h10, cause=3, redirect to VECTOR; ie=0 -> irq ignored.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared types for the memory-stage trap controller.
// Holds the sequencer state enum, trap cause codes and system-register indices.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_SCALL = 2'd1;
    localparam logic [1:0] CAUSE_UDF   = 2'd2;
    localparam logic [1:0] CAUSE_IRQ   = 2'd3;

    localparam logic [1:0] SR_EPC    = 2'd0;
    localparam logic [1:0] SR_CAUSE  = 2'd1;
    localparam logic [1:0] SR_STATUS = 2'd2;

endpackage

// File: rtl/trap_ctrl.sv
// Retire-stage trap controller: registered writeback, epc/cause/ie, and a
// RUN -> FLUSH -> REDIR sequence for udf, scall, eret (and optional irq).
// Ports: clk, rst (async, active-high); m_* retiring-slot inputs from mem;
// rf_* / cr_* writeback ports; flush; redir_valid/redir_pc; epc, cause, ie.
// Build macro TRAP_CTRL_IRQ_EN adds the level-sensitive irq input.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_nextpc,
    input  logic [31:0] m_res,
    input  logic [4:0]  m_rd,
    input  logic        m_w_rd,
    input  logic [1:0]  m_cmp_res,
    input  logic        m_w_cr,
    input  logic [31:0] m_op3,
    input  logic [31:0] m_alu_res,
    input  logic        m_mtsr,
    input  logic        m_scall,
    input  logic        m_eret,
    input  logic        m_udf,
    input  logic        m_bubble,
    input  logic        m_stall,
`ifdef TRAP_CTRL_IRQ_EN
    input  logic        irq,
`endif
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        cr_we,
    output logic [1:0]  cr_wdata,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        ie
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] tgt;

    logic retire;
    logic take_udf;
    logic take_scall;
    logic take_eret;
    logic take_mtsr;
    logic take_irq;
    logic kill_wb;
    logic go_trap;

    // Only the low two bits of the ALU result select a system register.
    logic unused_alu_hi;
    assign unused_alu_hi = ^m_alu_res[31:2];

    assign retire = !m_bubble && !m_stall && (state == RUN);

    always_comb begin
        take_udf   = retire && m_udf;
        take_scall = retire && !m_udf && m_scall;
        take_eret  = retire && !m_udf && !m_scall && m_eret;
        take_mtsr  = retire && !m_udf && !m_scall && !m_eret && m_mtsr;
`ifdef TRAP_CTRL_IRQ_EN
        // eret re-enables ie, so an irq cannot be taken on that same retire.
        take_irq   = retire && !m_udf && !m_scall && !m_eret && irq && ie;
`else
        take_irq   = 1'b0;
`endif
        kill_wb    = take_udf || take_scall;
        go_trap    = take_udf || take_scall || take_eret || take_irq;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (go_trap) state_nxt = FLUSH;
            FLUSH:   state_nxt = REDIR;
            REDIR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            cr_we    <= 1'b0;
            cr_wdata <= '0;
        end else begin
            rf_we <= retire && m_w_rd && (m_rd != 5'd0) && !kill_wb;
            cr_we <= retire && m_w_cr && !kill_wb;
            if (retire) begin
                rf_waddr <= m_rd;
                rf_wdata <= m_res;
                cr_wdata <= m_cmp_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc   <= '0;
            cause <= CAUSE_NONE;
            ie    <= 1'b0;
            tgt   <= '0;
        end else if (take_udf) begin
            epc   <= m_pc;
            cause <= CAUSE_UDF;
            ie    <= 1'b0;
            tgt   <= VECTOR;
        end else if (take_scall) begin
            epc   <= m_nextpc;
            cause <= CAUSE_SCALL;
            ie    <= 1'b0;
            tgt   <= VECTOR;
        end else if (take_eret) begin
            ie  <= 1'b1;
            tgt <= epc;
        end else begin
            if (take_mtsr) begin
                unique case (m_alu_res[1:0])
                    SR_EPC:    epc   <= m_op3;
                    SR_CAUSE:  cause <= m_op3[1:0];
                    SR_STATUS: ie    <= m_op3[0];
                    default:   ;
                endcase
            end
            // An irq overrides a same-slot mtsr so the return path stays sane.
            if (take_irq) begin
                epc   <= m_nextpc;
                cause <= CAUSE_IRQ;
                ie    <= 1'b0;
                tgt   <= VECTOR;
            end
        end
    end

    assign flush       = (state == FLUSH);
    assign redir_valid = (state == REDIR);
    assign redir_pc    = (state == REDIR) ? tgt : '0;

endmodule
